delta_dram_arbiter: RTL and testbench
=====================================

# delta_dram_arbiter

Round-robin arbiter sharing the single DRAM port among the Delta accelerator's loaders and writers. Requester 0 is the input loader, 1 the weight loader and 2 the output writer. It grants one requester at a time and forwards that requester's read or write to DRAM. A requester may lock the grant so that a multi-word burst (e.g. four 32-bit reads assembling one 128-bit SRAM line) is not interleaved with other traffic.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- ADDR_W, 32, DRAM address width
- DATA_W, 32, DRAM data width
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- req_read  in  NUM_REQ  per-requester read request, level, held until its req_ready
- req_write  in  NUM_REQ  per-requester write request, level, held until its req_ready
- req_lock  in  NUM_REQ  keep grant after current access completes
- req_addr  in  NUM_REQ*ADDR_W  flattened; slice i = requester i address
- req_wdata  in  NUM_REQ*DATA_W  flattened write data
- req_rdata  out  DATA_W  DRAM_ReadData broadcast to all requesters
- req_ready  out  NUM_REQ  one-hot completion pulse to granted requester
- DRAM_Read  out  1  DRAM read strobe
- DRAM_Write  out  1  DRAM write strobe
- DRAM_Address  out  ADDR_W  DRAM address
- DRAM_WriteData  out  DATA_W  DRAM write data
- DRAM_ReadData  in  DATA_W  DRAM read data
- DRAM_DataReady  in  1  read data valid / write accepted, one-cycle pulse
- grant  out  NUM_REQ  registered one-hot current owner, 0 in IDLE
- busy  out  1  state != IDLE
- protocol_err  out  1  sticky; cleared only by reset

## Operation
- States: IDLE, ACCESS, HOLD.
- Request of i: req_read[i] | req_write[i].
- IDLE:
  - Pick the first requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
  - Register grant = onehot(winner); go to ACCESS. No requester: stay.
- ACCESS:
  - DRAM_Read = req_read[g], DRAM_Write = req_write[g], DRAM_Address and DRAM_WriteData = slice g, combinationally muxed.
  - On DRAM_DataReady: req_ready[g] = 1 in that same cycle; rr_ptr <= (g+1) mod NUM_REQ.
  - Then next state = HOLD if req_lock[g], else IDLE with grant cleared.
- HOLD:
  - DRAM strobes are 0; grant is retained.
  - Request of g: go to ACCESS.
  - !req_lock[g] and no request of g: go to IDLE, clear grant.
  - Other requesters wait; HOLD has no timeout.
- Read and write from the granted requester at the same time is illegal: the read is forwarded, the write is ignored, and protocol_err is set.
- Granted requester drops its request in ACCESS before DataReady: set protocol_err, go to IDLE. DRAM_DataReady arriving in IDLE/HOLD is ignored (no req_ready) and sets protocol_err.
- req_rdata = DRAM_ReadData always (pass-through).
- Outputs outside ACCESS: DRAM_Read = DRAM_Write = 0, DRAM_Address = 0, DRAM_WriteData = 0, req_ready = 0.

## Timing
- Reset: state = IDLE, grant = 0, rr_ptr = 0, protocol_err = 0; all outputs 0.
- Reset mid-access drops strobes the next cycle; no req_ready is issued.
- Arbitration latency: request seen in IDLE at cycle t; DRAM strobe asserted from cycle t+1.
- Completion: req_ready coincides with DRAM_DataReady (zero added latency).
- Earliest next strobe after completion: t+2 when re-arbitrating from IDLE, or from HOLD with a locked re-request.
- A locked requester that re-requests one cycle after req_ready (loader IDX_PLUS gap) keeps the port; no other requester can intervene.
- Simultaneous requests go to the first at or after rr_ptr. With all NUM_REQ requesting continuously and unlocked, grants rotate 0,1,2,0...
- rr_ptr wraps from NUM_REQ-1 to 0.
- DataReady in the same cycle ACCESS is entered (from IDLE) is valid: the strobe is already driven.

## Test plan
- Reset, then req_read = 3'b001, addr 0x100, DataReady after 3 cycles with data 0xDEADBEEF. Required: DRAM_Read high cycles t+1..t+4, address 0x100, req_ready[0] pulses with rdata 0xDEADBEEF, grant returns to 0.
- req_read = 3'b111 continuously, unlocked, DataReady every 2 cycles. Required: grant order 001, 010, 100, 001.
- Requester 0 locked, four reads at 0x200/0x204/0x208/0x20C, 1-cycle gap each; requester 1 requesting throughout. Required: no grant to 1 until 0 drops lock after the fourth req_ready; then grant = 010.
- Requester 2 write to 0x300 with data 0x12345678. Required: DRAM_Write = 1, DRAM_WriteData = 0x12345678; req_ready[2] on DataReady; DRAM_Read stays 0.
- Requester 1 asserts read and write together. Required: read forwarded, protocol_err = 1, still 1 after 10 idle cycles. Separately, spurious DataReady in IDLE sets protocol_err and produces no req_ready.
- Reset asserted while in ACCESS with DataReady pending. Required: next cycle strobes = 0, grant = 0, busy = 0, no req_ready.

Source files
------------

// File: rtl/delta_dram_arbiter_if.sv
// Requester-side and DRAM-side signals of the Delta DRAM arbiter.
// Handshake: a requester holds req_read/req_write (plus addr/wdata) until it sees its req_ready bit; req_ready pulses together with DRAM_DataReady.
interface delta_dram_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_read;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0]         req_rdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      DRAM_Read;
    logic                      DRAM_Write;
    logic [ADDR_W-1:0]         DRAM_Address;
    logic [DATA_W-1:0]         DRAM_WriteData;
    logic [DATA_W-1:0]         DRAM_ReadData;
    logic                      DRAM_DataReady;

    modport master (
        output req_read, req_write, req_lock, req_addr, req_wdata,
        output DRAM_ReadData, DRAM_DataReady,
        input  req_rdata, req_ready,
        input  DRAM_Read, DRAM_Write, DRAM_Address, DRAM_WriteData
    );

    modport slave (
        input  req_read, req_write, req_lock, req_addr, req_wdata,
        input  DRAM_ReadData, DRAM_DataReady,
        output req_rdata, req_ready,
        output DRAM_Read, DRAM_Write, DRAM_Address, DRAM_WriteData
    );
endinterface

// File: rtl/delta_dram_arbiter.sv
// Round-robin arbiter sharing one DRAM port among the Delta loaders/writer,
// with per-requester grant locking for multi-word bursts.
module delta_dram_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    delta_dram_arbiter_if.slave  bus,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 protocol_err,
    output logic [1:0]           fsm_state
);
    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;

    logic [1:0]         state;
    logic [NUM_REQ-1:0] grant_q;
    logic [IDXW-1:0]    g_idx;
    logic [IDXW-1:0]    rr_ptr;
    logic               perr_q;

    logic [NUM_REQ-1:0] req_any;
    logic               win_found;
    logic [IDXW-1:0]    win_idx;
    logic [IDXW-1:0]    cand;
    logic [IDXW-1:0]    next_ptr;
    logic               g_read;
    logic               g_write;
    logic               g_req;
    logic               g_lock;

    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

    logic               dram_read;
    logic               dram_write;
    logic [ADDR_W-1:0]  dram_addr;
    logic [DATA_W-1:0]  dram_wdata;
    logic [NUM_REQ-1:0] ready;

    assign req_any = bus.req_read | bus.req_write;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i]  = bus.req_addr[i*ADDR_W +: ADDR_W];
            wdata_arr[i] = bus.req_wdata[i*DATA_W +: DATA_W];
        end
    end

    // First requester at or after rr_ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDXW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!win_found && req_any[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign next_ptr = (g_idx == IDXW'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
    assign g_read   = bus.req_read[g_idx];
    assign g_write  = bus.req_write[g_idx];
    assign g_req    = g_read | g_write;
    assign g_lock   = bus.req_lock[g_idx];

    // A simultaneous read+write forwards only the read.
    always_comb begin
        dram_read  = 1'b0;
        dram_write = 1'b0;
        dram_addr  = '0;
        dram_wdata = '0;
        ready      = '0;
        if (state == ACCESS) begin
            dram_read  = g_read;
            dram_write = g_write & ~g_read;
            dram_addr  = addr_arr[g_idx];
            dram_wdata = wdata_arr[g_idx];
            if (bus.DRAM_DataReady && g_req)
                ready = grant_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            grant_q <= '0;
            g_idx   <= '0;
            rr_ptr  <= '0;
            perr_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.DRAM_DataReady)
                        perr_q <= 1'b1;
                    if (win_found) begin
                        state   <= ACCESS;
                        g_idx   <= win_idx;
                        grant_q <= NUM_REQ'(1) << win_idx;
                    end
                end
                ACCESS: begin
                    if (g_read && g_write)
                        perr_q <= 1'b1;
                    if (!g_req) begin
                        perr_q  <= 1'b1;
                        state   <= IDLE;
                        grant_q <= '0;
                    end else if (bus.DRAM_DataReady) begin
                        rr_ptr <= next_ptr;
                        if (g_lock) begin
                            state <= HOLD;
                        end else begin
                            state   <= IDLE;
                            grant_q <= '0;
                        end
                    end
                end
                HOLD: begin
                    if (bus.DRAM_DataReady)
                        perr_q <= 1'b1;
                    if (g_req) begin
                        state <= ACCESS;
                    end else if (!g_lock) begin
                        state   <= IDLE;
                        grant_q <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign bus.DRAM_Read      = dram_read;
    assign bus.DRAM_Write     = dram_write;
    assign bus.DRAM_Address   = dram_addr;
    assign bus.DRAM_WriteData = dram_wdata;
    assign bus.req_ready      = ready;
    assign bus.req_rdata      = bus.DRAM_ReadData;

    assign grant        = grant_q;
    assign busy         = (state != IDLE);
    assign protocol_err = perr_q;
    assign fsm_state    = state;
endmodule

// File: tb/tb_delta_dram_arbiter.sv
// Directed bench for delta_dram_arbiter: arbitration, locking, writes,
// protocol errors and reset behaviour.
module tb_delta_dram_arbiter;
    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam logic [1:0] HOLD_ST = 2'd2;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [NUM_REQ-1:0] grant;
    logic               busy;
    logic               protocol_err;
    logic [1:0]         fsm_state;

    int vectors     = 0;
    int miscompares = 0;

    delta_dram_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    delta_dram_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus.slave),
        .grant        (grant),
        .busy         (busy),
        .protocol_err (protocol_err),
        .fsm_state    (fsm_state)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic clear_inputs;
        bus.req_read       = '0;
        bus.req_write      = '0;
        bus.req_lock       = '0;
        bus.req_addr       = '0;
        bus.req_wdata      = '0;
        bus.DRAM_ReadData  = '0;
        bus.DRAM_DataReady = 1'b0;
    endtask

    task automatic apply_reset;
        tick;
        reset = 1'b1;
        clear_inputs;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs;
        reset = 1'b1;
        tick;
        tick;
        settle;
        vectors++; if (grant !== 3'b000) begin miscompares++; $display("FAIL reset_grant: got %b want 000", grant); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (protocol_err !== 1'b0) begin miscompares++; $display("FAIL reset_perr: got %b want 0", protocol_err); end
        vectors++; if ({bus.DRAM_Read, bus.DRAM_Write} !== 2'b00) begin miscompares++; $display("FAIL reset_strobes: got %b want 00", {bus.DRAM_Read, bus.DRAM_Write}); end
        vectors++; if (bus.DRAM_Address !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h want 0", bus.DRAM_Address); end
        vectors++; if (bus.req_ready !== 3'b000) begin miscompares++; $display("FAIL reset_ready: got %b want 000", bus.req_ready); end
        reset = 1'b0;
    endtask

    task automatic test_single_read;
        bus.req_read = 3'b001;
        bus.req_addr[0 +: ADDR_W] = 32'h100;
        settle;
        vectors++; if (bus.DRAM_Read !== 1'b0) begin miscompares++; $display("FAIL sr_idle_read: got %b want 0", bus.DRAM_Read); end
        for (int c = 1; c <= 4; c++) begin
            tick;
            if (c == 4) begin
                bus.DRAM_DataReady = 1'b1;
                bus.DRAM_ReadData  = 32'hDEADBEEF;
            end
            settle;
            vectors++; if (bus.DRAM_Read !== 1'b1) begin miscompares++; $display("FAIL sr_read_t%0d: got %b want 1", c, bus.DRAM_Read); end
            vectors++; if (grant !== 3'b001) begin miscompares++; $display("FAIL sr_grant_t%0d: got %b want 001", c, grant); end
            vectors++; if (bus.DRAM_Address !== 32'h100) begin miscompares++; $display("FAIL sr_addr_t%0d: got %h want 100", c, bus.DRAM_Address); end
            vectors++; if (bus.req_ready !== ((c == 4) ? 3'b001 : 3'b000)) begin miscompares++; $display("FAIL sr_ready_t%0d: got %b want %b", c, bus.req_ready, (c == 4) ? 3'b001 : 3'b000); end
        end
        vectors++; if (bus.req_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL sr_rdata: got %h want deadbeef", bus.req_rdata); end
        tick;
        bus.DRAM_DataReady = 1'b0;
        bus.req_read = 3'b000;
        settle;
        vectors++; if (grant !== 3'b000) begin miscompares++; $display("FAIL sr_grant_after: got %b want 000", grant); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL sr_busy_after: got %b want 0", busy); end
        vectors++; if (bus.DRAM_Read !== 1'b0) begin miscompares++; $display("FAIL sr_read_after: got %b want 0", bus.DRAM_Read); end
    endtask

    task automatic test_rotation;
        logic [2:0] exp_g [4];
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
        apply_reset;
        bus.req_read = 3'b111;
        settle;
        for (int i = 0; i < 4; i++) begin
            tick;
            settle;
            vectors++; if (grant !== exp_g[i]) begin miscompares++; $display("FAIL rot_grant_%0d: got %b want %b", i, grant, exp_g[i]); end
            bus.DRAM_DataReady = 1'b1;
            settle;
            vectors++; if (bus.req_ready !== exp_g[i]) begin miscompares++; $display("FAIL rot_ready_%0d: got %b want %b", i, bus.req_ready, exp_g[i]); end
            tick;
            bus.DRAM_DataReady = 1'b0;
            if (i == 3) bus.req_read = 3'b000;
            settle;
            vectors++; if (grant !== 3'b000) begin miscompares++; $display("FAIL rot_idle_%0d: got %b want 000", i, grant); end
        end
    endtask

    task automatic test_lock;
        logic [31:0] exp_addr;
        apply_reset;
        bus.req_lock = 3'b001;
        bus.req_read = 3'b011;
        bus.req_addr[0 +: ADDR_W]      = 32'h200;
        bus.req_addr[ADDR_W +: ADDR_W] = 32'h400;
        settle;
        tick;
        for (int n = 0; n < 4; n++) begin
            exp_addr = 32'h200 + 32'(4 * n);
            settle;
            vectors++; if (grant !== 3'b001) begin miscompares++; $display("FAIL lock_grant_%0d: got %b want 001", n, grant); end
            vectors++; if (bus.DRAM_Read !== 1'b1) begin miscompares++; $display("FAIL lock_read_%0d: got %b want 1", n, bus.DRAM_Read); end
            vectors++; if (bus.DRAM_Address !== exp_addr) begin miscompares++; $display("FAIL lock_addr_%0d: got %h want %h", n, bus.DRAM_Address, exp_addr); end
            bus.DRAM_DataReady = 1'b1;
            settle;
            vectors++; if (bus.req_ready !== 3'b001) begin miscompares++; $display("FAIL lock_ready_%0d: got %b want 001", n, bus.req_ready); end
            tick;
            bus.DRAM_DataReady = 1'b0;
            bus.req_read[0] = 1'b0;
            if (n == 3) bus.req_lock[0] = 1'b0;
            settle;
            vectors++; if (grant !== 3'b001) begin miscompares++; $display("FAIL lock_hold_grant_%0d: got %b want 001", n, grant); end
            vectors++; if (fsm_state !== HOLD_ST) begin miscompares++; $display("FAIL lock_hold_state_%0d: got %0d want 2", n, fsm_state); end
            vectors++; if (bus.DRAM_Read !== 1'b0) begin miscompares++; $display("FAIL lock_hold_read_%0d: got %b want 0", n, bus.DRAM_Read); end
            if (n < 3) begin
                tick;
                bus.req_read[0] = 1'b1;
                bus.req_addr[0 +: ADDR_W] = 32'h200 + 32'(4 * (n + 1));
                settle;
                vectors++; if (grant !== 3'b001) begin miscompares++; $display("FAIL lock_gap_grant_%0d: got %b want 001", n, grant); end
                tick;
            end
        end
        tick;
        settle;
        vectors++; if (grant !== 3'b000) begin miscompares++; $display("FAIL lock_release_idle: got %b want 000", grant); end
        tick;
        settle;
        vectors++; if (grant !== 3'b010) begin miscompares++; $display("FAIL lock_next_grant: got %b want 010", grant); end
        vectors++; if (bus.DRAM_Address !== 32'h400) begin miscompares++; $display("FAIL lock_next_addr: got %h want 400", bus.DRAM_Address); end
        bus.DRAM_DataReady = 1'b1;
        settle;
        vectors++; if (bus.req_ready !== 3'b010) begin miscompares++; $display("FAIL lock_next_ready: got %b want 010", bus.req_ready); end
        tick;
        bus.DRAM_DataReady = 1'b0;
        bus.req_read = 3'b000;
        settle;
    endtask

    task automatic test_write;
        bus.req_write = 3'b100;
        bus.req_addr[2*ADDR_W +: ADDR_W]  = 32'h300;
        bus.req_wdata[2*DATA_W +: DATA_W] = 32'h12345678;
        settle;
        tick;
        settle;
        vectors++; if (grant !== 3'b100) begin miscompares++; $display("FAIL wr_grant: got %b want 100", grant); end
        vectors++; if ({bus.DRAM_Read, bus.DRAM_Write} !== 2'b01) begin miscompares++; $display("FAIL wr_strobes: got %b want 01", {bus.DRAM_Read, bus.DRAM_Write}); end
        vectors++; if (bus.DRAM_WriteData !== 32'h12345678) begin miscompares++; $display("FAIL wr_data: got %h want 12345678", bus.DRAM_WriteData); end
        vectors++; if (bus.DRAM_Address !== 32'h300) begin miscompares++; $display("FAIL wr_addr: got %h want 300", bus.DRAM_Address); end
        tick;
        bus.DRAM_DataReady = 1'b1;
        settle;
        vectors++; if (bus.req_ready !== 3'b100) begin miscompares++; $display("FAIL wr_ready: got %b want 100", bus.req_ready); end
        vectors++; if (bus.DRAM_Read !== 1'b0) begin miscompares++; $display("FAIL wr_no_read: got %b want 0", bus.DRAM_Read); end
        tick;
        bus.DRAM_DataReady = 1'b0;
        bus.req_write = 3'b000;
        settle;
        vectors++; if ({busy, bus.DRAM_Write} !== 2'b00) begin miscompares++; $display("FAIL wr_after: got %b want 00", {busy, bus.DRAM_Write}); end
        vectors++; if (protocol_err !== 1'b0) begin miscompares++; $display("FAIL wr_perr_clean: got %b want 0", protocol_err); end
    endtask

    task automatic test_protocol;
        apply_reset;
        bus.req_read  = 3'b010;
        bus.req_write = 3'b010;
        settle;
        tick;
        settle;
        vectors++; if ({bus.DRAM_Read, bus.DRAM_Write} !== 2'b10) begin miscompares++; $display("FAIL rw_strobes: got %b want 10", {bus.DRAM_Read, bus.DRAM_Write}); end
        vectors++; if (grant !== 3'b010) begin miscompares++; $display("FAIL rw_grant: got %b want 010", grant); end
        bus.DRAM_DataReady = 1'b1;
        settle;
        vectors++; if (bus.req_ready !== 3'b010) begin miscompares++; $display("FAIL rw_ready: got %b want 010", bus.req_ready); end
        tick;
        bus.DRAM_DataReady = 1'b0;
        bus.req_read  = 3'b000;
        bus.req_write = 3'b000;
        settle;
        vectors++; if (protocol_err !== 1'b1) begin miscompares++; $display("FAIL rw_perr: got %b want 1", protocol_err); end
        repeat (10) tick;
        settle;
        vectors++; if (protocol_err !== 1'b1) begin miscompares++; $display("FAIL rw_perr_sticky: got %b want 1", protocol_err); end

        apply_reset;
        settle;
        vectors++; if (protocol_err !== 1'b0) begin miscompares++; $display("FAIL perr_cleared: got %b want 0", protocol_err); end
        bus.DRAM_DataReady = 1'b1;
        settle;
        vectors++; if (bus.req_ready !== 3'b000) begin miscompares++; $display("FAIL spur_ready: got %b want 000", bus.req_ready); end
        tick;
        bus.DRAM_DataReady = 1'b0;
        settle;
        vectors++; if (protocol_err !== 1'b1) begin miscompares++; $display("FAIL spur_perr: got %b want 1", protocol_err); end

        apply_reset;
        bus.req_read = 3'b100;
        tick;
        settle;
        vectors++; if (grant !== 3'b100) begin miscompares++; $display("FAIL drop_grant: got %b want 100", grant); end
        bus.req_read = 3'b000;
        tick;
        settle;
        vectors++; if ({busy, grant} !== 4'b0000) begin miscompares++; $display("FAIL drop_idle: got %b want 0000", {busy, grant}); end
        vectors++; if (protocol_err !== 1'b1) begin miscompares++; $display("FAIL drop_perr: got %b want 1", protocol_err); end
    endtask

    task automatic test_reset_mid_access;
        apply_reset;
        bus.req_read = 3'b001;
        bus.req_addr[0 +: ADDR_W] = 32'h500;
        tick;
        settle;
        vectors++; if (bus.DRAM_Read !== 1'b1) begin miscompares++; $display("FAIL rma_read: got %b want 1", bus.DRAM_Read); end
        reset = 1'b1;
        tick;
        bus.DRAM_DataReady = 1'b1;
        settle;
        vectors++; if ({bus.DRAM_Read, bus.DRAM_Write} !== 2'b00) begin miscompares++; $display("FAIL rma_strobes: got %b want 00", {bus.DRAM_Read, bus.DRAM_Write}); end
        vectors++; if (grant !== 3'b000) begin miscompares++; $display("FAIL rma_grant: got %b want 000", grant); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rma_busy: got %b want 0", busy); end
        vectors++; if (bus.req_ready !== 3'b000) begin miscompares++; $display("FAIL rma_ready: got %b want 000", bus.req_ready); end
        clear_inputs;
        reset = 1'b0;
        tick;
    endtask

    initial begin
        test_reset;
        test_single_read;
        test_rotation;
        test_lock;
        test_write;
        test_protocol;
        test_reset_mid_access;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
